// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter that shares one register-file read port among NUM_REQ requesters
// and returns the read data to the granted requester with a fixed two-cycle latency.
module regfile_read_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 64,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0][4:0]       req_addr,
  input  logic                          stall,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [4:0]                    ReadRegister,
  input  logic [DATA_WIDTH-1:0]         OutputData,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr_q;
  logic                  win_vld_p0;
  logic [PTR_W-1:0]      win_id_p0;
  logic [NUM_REQ-1:0]    gnt_p0;
  logic                  vld_p1_q;
  logic [PTR_W-1:0]      id_p1_q;
  logic [4:0]            raddr_p1_q;
  logic [NUM_REQ-1:0]    rd_valid_p2_q;
  logic [DATA_WIDTH-1:0] rd_data_p2_q;

  // (base + offset) mod NUM_REQ, for offset < NUM_REQ
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int offset);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(offset);
    if (sum >= (PTR_W+1)'(NUM_REQ))
      sum = sum - (PTR_W+1)'(NUM_REQ);
    return sum[PTR_W-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zero_reg_mask(input logic [4:0] raddr,
                                                          input logic [DATA_WIDTH-1:0] data);
    if (ZERO_REG_EN && (raddr == 5'd31))
      return '0;
    return data;
  endfunction

  // Stage 0: combinational round-robin search starting at ptr
  always_comb begin
    win_vld_p0 = 1'b0;
    win_id_p0  = '0;
    gnt_p0     = '0;
    if (reset && !stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!win_vld_p0 && req[wrap_idx(ptr_q, k)]) begin
          win_vld_p0 = 1'b1;
          win_id_p0  = wrap_idx(ptr_q, k);
        end
      end
    end
    if (win_vld_p0)
      gnt_p0[win_id_p0] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      ptr_q <= '0;
    else if (win_vld_p0)
      ptr_q <= wrap_idx(win_id_p0, 1);
  end

  // Stage 1: drive the read-register select from the winner
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p1_q   <= 1'b0;
      id_p1_q    <= '0;
      raddr_p1_q <= 5'd31;
    end else begin
      vld_p1_q <= win_vld_p0;
      if (win_vld_p0) begin
        id_p1_q    <= win_id_p0;
        raddr_p1_q <= req_addr[win_id_p0];
      end
    end
  end

  // Stage 2: capture mux output and return it to the requester
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid_p2_q <= '0;
      rd_data_p2_q  <= '0;
    end else if (vld_p1_q) begin
      rd_valid_p2_q <= NUM_REQ'(1) << id_p1_q;
      rd_data_p2_q  <= zero_reg_mask(raddr_p1_q, OutputData);
    end else begin
      rd_valid_p2_q <= '0;
    end
  end

  assign gnt          = gnt_p0;
  assign ReadRegister = raddr_p1_q;
  assign rd_valid     = rd_valid_p2_q;
  assign rd_data      = rd_data_p2_q;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: a behavioural 32-entry read mux feeds two
// instances (XZR enabled and disabled) that share all request-side stimulus.
module tb_regfile_read_arbiter;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      req;
  logic [3:0][4:0] req_addr;
  logic            stall;
  logic [3:0]      gnt, gnt_nz;
  logic [4:0]      rreg, rreg_nz;
  logic [63:0]     od, od_nz;
  logic [3:0]      rd_valid, rd_valid_nz;
  logic [63:0]     rd_data, rd_data_nz;
  logic [63:0]     mem [32];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign od    = mem[rreg];
  assign od_nz = mem[rreg_nz];

  regfile_read_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64), .ZERO_REG_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .stall(stall),
    .gnt(gnt), .ReadRegister(rreg), .OutputData(od),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  regfile_read_arbiter #(.NUM_REQ(4), .DATA_WIDTH(64), .ZERO_REG_EN(1'b0)) dut_nz (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .stall(stall),
    .gnt(gnt_nz), .ReadRegister(rreg_nz), .OutputData(od_nz),
    .rd_valid(rd_valid_nz), .rd_data(rd_data_nz)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 32; k++)
      mem[k] = 64'hA5A5_0000_0000_0000 | 64'(k);
    mem[5]  = 64'hDEAD_BEEF_0000_0005;
    mem[31] = 64'hFFFF_FFFF_FFFF_FFFF;

    reset    = 1'b0;
    stall    = 1'b0;
    req      = 4'b1111;
    req_addr = '0;

    // Reset state, with requests pending to show gnt is forced low
    step();
    step();
    #1;
    chk("rst_rreg", 64'(rreg), 64'd31);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    req   = 4'b0000;
    reset = 1'b1;
    step();

    // Single read of register 5 by requester 0
    req         = 4'b0001;
    req_addr[0] = 5'd5;
    #1;
    chk("single_gnt", 64'(gnt), 64'b0001);
    step();
    req = 4'b0000;
    #1;
    chk("single_rreg", 64'(rreg), 64'd5);
    chk("single_rd_valid_n1", 64'(rd_valid), 64'd0);
    step();
    #1;
    chk("single_rd_valid", 64'(rd_valid), 64'b0001);
    chk("single_rd_data", rd_data, 64'hDEAD_BEEF_0000_0005);

    // Reset mid-flight: requester 3 granted, reset sampled at the following edge
    req         = 4'b1000;
    req_addr[3] = 5'd7;
    #1;
    chk("midrst_gnt", 64'(gnt), 64'b1000);
    reset = 1'b0;
    step();
    req   = 4'b0000;
    reset = 1'b1;
    #1;
    chk("midrst_rreg", 64'(rreg), 64'd31);
    step();
    #1;
    chk("midrst_rd_valid", 64'(rd_valid), 64'd0);

    // Round-robin with all four requesting; ptr restarts at 0 after reset
    for (int i = 0; i < 4; i++)
      req_addr[i] = 5'(i + 1);
    for (int c = 0; c < 10; c++) begin
      req = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      chk($sformatf("rr_gnt_%0d", c), 64'(gnt), (c < 8) ? 64'(1) << (c % 4) : 64'd0);
      if (c >= 2) begin
        chk($sformatf("rr_rd_valid_%0d", c), 64'(rd_valid), 64'(1) << ((c - 2) % 4));
        chk($sformatf("rr_rd_data_%0d", c), rd_data, mem[((c - 2) % 4) + 1]);
      end else begin
        chk($sformatf("rr_rd_valid_%0d", c), 64'(rd_valid), 64'd0);
      end
      step();
    end

    // Pointer skip and wrap: grant 2, then 0 (wrapping past 3), then 1, then ptr=2
    req = 4'b0100;
    #1;
    chk("skip_gnt2", 64'(gnt), 64'b0100);
    step();
    req = 4'b0011;
    #1;
    chk("skip_gnt0", 64'(gnt), 64'b0001);
    step();
    #1;
    chk("skip_gnt1", 64'(gnt), 64'b0010);
    step();
    req = 4'b1111;
    #1;
    chk("skip_ptr2", 64'(gnt), 64'b0100);
    step();

    // Stall while a read from requester 0 is in flight
    req         = 4'b0001;
    req_addr[0] = 5'd9;
    #1;
    chk("stall_pre_gnt", 64'(gnt), 64'b0001);
    step();
    req   = 4'b0010;
    stall = 1'b1;
    #1;
    chk("stall_gnt_a", 64'(gnt), 64'd0);
    chk("stall_rreg", 64'(rreg), 64'd9);
    step();
    #1;
    chk("stall_gnt_b", 64'(gnt), 64'd0);
    chk("stall_inflight_valid", 64'(rd_valid), 64'b0001);
    chk("stall_inflight_data", rd_data, mem[9]);
    step();
    #1;
    chk("stall_gnt_c", 64'(gnt), 64'd0);
    chk("stall_rd_valid_idle", 64'(rd_valid), 64'd0);
    step();
    stall = 1'b0;
    #1;
    chk("unstall_gnt", 64'(gnt), 64'b0010);
    step();
    req = 4'b0000;
    #1;
    chk("unstall_rreg", 64'(rreg), 64'd2);
    step();
    #1;
    chk("unstall_rd_valid", 64'(rd_valid), 64'b0010);
    chk("unstall_rd_data", rd_data, mem[2]);

    // Zero register: mux entry 31 is all ones
    req         = 4'b0100;
    req_addr[2] = 5'd31;
    #1;
    chk("xzr_gnt", 64'(gnt), 64'b0100);
    step();
    req = 4'b0000;
    #1;
    chk("xzr_rreg", 64'(rreg), 64'd31);
    step();
    #1;
    chk("xzr_rd_valid", 64'(rd_valid), 64'b0100);
    chk("xzr_rd_data_en", rd_data, 64'd0);
    chk("xzr_rd_valid_dis", 64'(rd_valid_nz), 64'b0100);
    chk("xzr_rd_data_dis", rd_data_nz, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    #1;
    chk("idle_rd_valid", 64'(rd_valid), 64'd0);
    chk("idle_rd_data_hold", rd_data, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
